// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Receives 12-bit UART frames, LSB first on the line:
//     start(0), data[7:0], parity, stop(1), stop(1).
//   The rx pin is double-flopped. Every bit is sampled at mid-bit.
//   Each received byte is presented with a one-cycle data_valid strobe.
//   The parity_err and frame_err flags are qualified by data_valid.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   PARITY_ODD    0 = even parity expected, 1 = odd parity expected
//
// Ports
//   clk         in   clock, all logic on posedge
//   preset      in   synchronous reset, active-high
//   rx          in   asynchronous serial line, idles high
//   data        out  received byte, held until the next strobe
//   data_valid  out  one-cycle strobe; data and flags were updated
//   parity_err  out  parity mismatch on the last frame
//   frame_err   out  a stop bit was sampled 0 on the last frame
//   busy        out  high whenever the FSM is not in IDLE
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       preset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_stop1;
  logic            r_stop2;
  logic            r_rx_s1;
  logic            r_rx_s;
  logic [7:0]      r_data;
  logic            r_dv;
  logic            r_perr;
  logic            r_ferr;
  logic            r_busy;

  assign data       = r_data;
  assign data_valid = r_dv;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

  always_ff @(posedge clk) begin
    if (preset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop1 <= 1'b1;
      r_stop2 <= 1'b1;
      r_rx_s1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_data  <= 8'h00;
      r_dv    <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s  <= r_rx_s1;
      r_dv    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        // The counter restarts at the middle of the start bit.
        // Every later sample point at LAST therefore lands mid-bit.
        ST_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= ST_IDLE;  // glitch, not a real start bit
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= ST_PARITY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s;
            r_state <= ST_STOP1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP1: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_stop1 <= r_rx_s;
            r_state <= ST_STOP2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP2: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_stop2 <= r_rx_s;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Returning to IDLE here accepts the next start edge about half a
        // stop bit early. Frames sent back to back therefore decode.
        ST_DONE: begin
          r_cnt   <= '0;
          r_data  <= r_shift;
          r_perr  <= ((^r_shift) ^ r_par) != PARITY_ODD;
          r_ferr  <= ~r_stop1 | ~r_stop2;
          r_dv    <= 1'b1;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       preset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .preset     (preset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       s1;
    logic       s2;
    int         gap;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   strobe_cyc[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called only at a negedge; leaves the caller at a negedge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s1);
    send_bit(s2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 20, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 20, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 20, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'hC3, 1'b0, 1'b1, 1'b1, 20, 8'hC3, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 20, 8'h80, 1'b0, 1'b0};
    tbl[5] = '{8'h7E, 1'b0, 1'b0, 1'b1, 20, 8'h7E, 1'b0, 1'b1};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 20, 8'hFF, 1'b1, 1'b0};

    rx     = 1'b1;
    preset = 1'b1;

    // This scoreboard process pops one expected entry per strobe.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (data_valid === 1'b1) begin
          strobe_cyc.push_back(cyc);
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe data=%h perr=%b ferr=%b", data, parity_err, frame_err);
          end else begin
            e = q.pop_front();
            if (data !== e.d || parity_err !== e.p || frame_err !== e.f) begin
              errors++;
              $display("FAIL strobe got d=%h p=%b f=%b expected d=%h p=%b f=%b",
                       data, parity_err, frame_err, e.d, e.p, e.f);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'h0);
    chk("rst_valid", {31'd0, data_valid}, 32'h0);
    chk("rst_perr", {31'd0, parity_err}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    preset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      q.push_back('{tbl[i].ed, tbl[i].ep, tbl[i].ef});
      send_frame(tbl[i].d, tbl[i].par, tbl[i].s1, tbl[i].s2);
      rx = 1'b1;
      repeat (tbl[i].gap) @(negedge clk);
    end
    wait_drain("table_drain");

    // Two frames sent back to back with no idle gap.
    strobe_cyc.delete();
    q.push_back('{8'h55, 1'b0, 1'b0});
    q.push_back('{8'hAA, 1'b0, 1'b0});
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b1);
    rx = 1'b1;
    wait_drain("b2b_drain");
    chk("b2b_count", strobe_cyc.size(), 2);
    if (strobe_cyc.size() == 2) chk("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 192);

    // A glitch shorter than half a bit must not produce a strobe.
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy}, 32'h1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy}, 32'h0);

    // Reset arrives during bit 4 of 8'hFF. The frame is dropped.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    preset = 1'b1;
    send_bit(1'b1);
    chk("midrst_data", {24'd0, data}, 32'h0);
    chk("midrst_valid", {31'd0, data_valid}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    preset = 1'b0;
    repeat (10) @(negedge clk);
    q.push_back('{8'h12, 1'b0, 1'b0});
    send_frame(8'h12, 1'b0, 1'b1, 1'b1);
    rx = 1'b1;
    wait_drain("post_rst_drain");

    // A break condition gives a framing error with data 00, then recovers.
    repeat (20) @(negedge clk);
    q.push_back('{8'h00, 1'b0, 1'b1});
    rx = 1'b0;
    repeat (11 * CPB + CPB / 2 + 2) @(negedge clk);
    rx = 1'b1;
    wait_drain("break_drain");
    repeat (40) @(negedge clk);
    chk("break_busy_lo", {31'd0, busy}, 32'h0);
    chk("break_hold_ferr", {31'd0, frame_err}, 32'h1);

    repeat (50) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
